key_filter: RTL and testbench
=============================

Name: key_filter

Overview:
- Upstream input stage for the LED blink logic. It synchronises one mechanical push-button, debounces it, and issues single-cycle press/release events plus a debounced level.
- The LED control stage consumes key_flag to change its blink behaviour.
- Timing targets the 50 MHz board clock.
- Key is active-low: pressed = 0.

Parameters:
- CNT_MAX, 1_000_000, debounce window in clk cycles (20 ms @ 50 MHz); legal range 2..2^CNT_W-1.
- LONG_MAX, 50_000_000, hold time in clk cycles before long_flag fires (1 s @ 50 MHz); only used with KEY_LONG_PRESS_EN; must be > CNT_MAX.
- CNT_W, 26, width of internal counters; must hold max(CNT_MAX, LONG_MAX).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset; sampled only on posedge clk.
- key_in  input  1  raw button, asynchronous, active-low, may bounce.
- key_flag  output  1  one-cycle pulse on confirmed press.
- rel_flag  output  1  one-cycle pulse on confirmed release.
- key_state  output  1  debounced level: 1 = pressed.
- long_flag  output  1  one-cycle pulse after LONG_MAX cycles held (KEY_LONG_PRESS_EN only, else tied 0).

Behaviour:
Synchroniser:
- Two-flop synchroniser key_s1 -> key_s2. Both reset to 1 (released).
- The FSM uses key_s2 only.

FSM states: IDLE, PRESS_FLT, DOWN, REL_FLT. Reset state is IDLE, cnt=0.
- IDLE: if key_s2==0 -> PRESS_FLT, cnt=0.
- PRESS_FLT: cnt increments each cycle while key_s2==0.
  - If key_s2==1 at any cycle (bounce) -> IDLE, cnt=0, no flag.
  - When cnt==CNT_MAX-1 and key_s2==0 -> DOWN, cnt=0.
  - key_flag=1 for exactly the next cycle.
  - key_state=1 from that same cycle.
- DOWN: if key_s2==1 -> REL_FLT, cnt=0. Otherwise, with the feature enabled, long counter runs (see Optional Feature).
- REL_FLT: mirror of PRESS_FLT with key_s2==1.
  - Bounce back to 0 -> DOWN. The long counter is not cleared, and no new key_flag is issued.
  - When cnt==CNT_MAX-1 -> IDLE, rel_flag=1 for one cycle, key_state=0.

Latency:
- Steady key_in falling edge -> key_flag high = 2 (sync) + 1 (IDLE exit) + CNT_MAX cycles.
- Release path latency is identical.

Flags:
- key_flag, rel_flag and long_flag are mutually exclusive.
- No flag is ever wider than 1 cycle.
- At most one key_flag per physical press.

Counters:
- Unsigned, CNT_W bits; they never wrap.
- Compare uses ==, and cnt is cleared on every state change.

Reset:
- rst mid-operation (any state) -> next edge: IDLE, cnt=0, long cnt=0, synchroniser=1.
- All outputs 0 the cycle after rst is sampled.
- A key held through reset release is re-filtered from scratch and produces a fresh key_flag.

Reset values: key_flag=0, rel_flag=0, key_state=0, long_flag=0.

Optional Feature:
- Macro: KEY_LONG_PRESS_EN.
- Defined:
  - In DOWN, a long counter increments every cycle.
  - When it reaches LONG_MAX-1, long_flag pulses once and the counter saturates. There is no repeat until the next press.
  - The long counter is cleared on entry to DOWN from PRESS_FLT and in IDLE.
  - Time spent in REL_FLT still counts.
- Undefined:
  - No long counter logic is instantiated.
  - long_flag is driven constant 0.

Test Plan (sim params CNT_MAX=10, LONG_MAX=40):
- Reset: hold rst=1 for 3 cycles with key_in=0 -> all outputs 0; after release, key_flag pulses at cycle 13 from rst deassert.
- Clean press: key_in 1->0 held 30 cycles -> key_flag high exactly 1 cycle, 13 cycles after edge; key_state=1 thereafter.
- Bounce: key_in low 5, high 2, low 4, high 3, then low steady -> no flag until 13 cycles after final falling edge; exactly one key_flag.
- Release with bounce: from DOWN, key_in high 4, low 1, high steady -> rel_flag once, 13 cycles after final rising edge; key_state=0 same cycle; no extra key_flag.
- Long press (KEY_LONG_PRESS_EN defined): hold 100 cycles -> key_flag once, long_flag once 40 cycles after key_flag; long_flag stays 0 when the macro is undefined.
- Reset mid-filter: rst asserted at cnt=6 in PRESS_FLT -> state IDLE, no key_flag; key still low after rst -> key_flag 13 cycles later.

Source files
------------

// File: rtl/key_filter.sv
// Push-button front end: two-flop synchroniser, debounce FSM, press/release pulses and debounced level.
// Optional KEY_LONG_PRESS_EN adds a saturating hold counter that fires long_flag once per press.
module key_filter #(
  parameter int CNT_MAX  = 1_000_000,
  parameter int LONG_MAX = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_flag,
  output logic rel_flag,
  output logic key_state,
  output logic long_flag
);

  // state     | meaning
  // IDLE      | key released and stable
  // PRESS_FLT | key seen low, waiting CNT_MAX stable cycles
  // DOWN      | key confirmed pressed
  // REL_FLT   | key seen high, waiting CNT_MAX stable cycles
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_FLT = 2'd1,
    DOWN      = 2'd2,
    REL_FLT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  if (CNT_MAX < 2 || LONG_MAX <= CNT_MAX) begin : g_bad_param
    $error("key_filter: CNT_MAX must be >= 2 and LONG_MAX must exceed CNT_MAX");
  end

  logic             key_s1_q, key_s1_d;
  logic             key_s2_q, key_s2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_flag_q, key_flag_d;
  logic             rel_flag_q, rel_flag_d;
  logic             key_state_q, key_state_d;
  logic             long_clr;

  always_comb begin
    key_s1_d    = key_in;
    key_s2_d    = key_s1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_flag_d  = 1'b0;
    rel_flag_d  = 1'b0;
    key_state_d = key_state_q;
    long_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!key_s2_q) begin
          state_d = PRESS_FLT;
        end
      end
      PRESS_FLT: begin
        if (key_s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = DOWN;
          cnt_d       = '0;
          key_flag_d  = 1'b1;
          key_state_d = 1'b1;
          long_clr    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOWN: begin
        cnt_d = '0;
        if (key_s2_q) begin
          state_d = REL_FLT;
        end
      end
      REL_FLT: begin
        // A bounce back low returns to DOWN silently; the hold count keeps running.
        if (!key_s2_q) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          rel_flag_d  = 1'b1;
          key_state_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1_q    <= 1'b1;
      key_s2_q    <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_flag_q  <= 1'b0;
      rel_flag_q  <= 1'b0;
      key_state_q <= 1'b0;
    end else begin
      key_s1_q    <= key_s1_d;
      key_s2_q    <= key_s2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_flag_q  <= key_flag_d;
      rel_flag_q  <= rel_flag_d;
      key_state_q <= key_state_d;
    end
  end

  assign key_flag  = key_flag_q;
  assign rel_flag  = rel_flag_q;
  assign key_state = key_state_q;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MAX - 1);
  localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_MAX);

  logic [CNT_W-1:0] long_cnt_q, long_cnt_d;
  logic             long_flag_q, long_flag_d;

  // Parking the count at LONG_MAX (one past the fire point) makes the pulse one-shot.
  always_comb begin
    long_cnt_d  = long_cnt_q;
    long_flag_d = 1'b0;
    if (state_q == IDLE || long_clr) begin
      long_cnt_d = '0;
    end else if (state_q == DOWN || state_q == REL_FLT) begin
      if (long_cnt_q == LONG_LAST) begin
        long_cnt_d  = LONG_SAT;
        long_flag_d = !rel_flag_d;
      end else if (long_cnt_q < LONG_LAST) begin
        long_cnt_d = long_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      long_cnt_q  <= '0;
      long_flag_q <= 1'b0;
    end else begin
      long_cnt_q  <= long_cnt_d;
      long_flag_q <= long_flag_d;
    end
  end

  assign long_flag = long_flag_q;
`else
  assign long_flag = 1'b0;
`endif

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with CNT_MAX=10, LONG_MAX=40.
// Latencies are counted in clock edges after the stimulus change.
`timescale 1ns/1ps
module tb_key_filter;

  localparam int CNT_MAX  = 10;
  localparam int LONG_MAX = 40;
  localparam int CNT_W    = 26;
  localparam int LAT      = 2 + 1 + CNT_MAX;

  logic clk = 1'b0;
  logic rst;
  logic key_in;
  logic key_flag, rel_flag, key_state, long_flag;

  int n_vec = 0;
  int n_err = 0;

  int kf_cnt, kf_first, rf_cnt, rf_first, lf_cnt, lf_first, multi_cnt;
  logic ks_hist [0:255];

  key_filter #(.CNT_MAX(CNT_MAX), .LONG_MAX(LONG_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_flag(key_flag), .rel_flag(rel_flag),
    .key_state(key_state), .long_flag(long_flag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance n edges, recording first occurrence and count of each pulse.
  task automatic watch(input int n);
    kf_cnt = 0; kf_first = -1; rf_cnt = 0; rf_first = -1;
    lf_cnt = 0; lf_first = -1; multi_cnt = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (i < 256) ks_hist[i] = key_state;
      if (key_flag  === 1'b1) begin kf_cnt++; if (kf_first < 0) kf_first = i; end
      if (rel_flag  === 1'b1) begin rf_cnt++; if (rf_first < 0) rf_first = i; end
      if (long_flag === 1'b1) begin lf_cnt++; if (lf_first < 0) lf_first = i; end
      if (int'(key_flag) + int'(rel_flag) + int'(long_flag) > 1) multi_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; key_in = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      n_vec++;
      if ({key_flag, rel_flag, key_state, long_flag} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 0000", c,
                 {key_flag, rel_flag, key_state, long_flag});
      end
    end
    rst = 1'b0;
    watch(20);
    n_vec++;
    if (kf_cnt !== 1 || kf_first !== LAT) begin
      n_err++;
      $display("FAIL reset_refilter: key_flag count %0d at %0d, expected 1 at %0d", kf_cnt, kf_first, LAT);
    end
    key_in = 1'b1;
    watch(20);
    n_vec++;
    if (rf_cnt !== 1 || rf_first !== LAT) begin
      n_err++;
      $display("FAIL reset_release: rel_flag count %0d at %0d, expected 1 at %0d", rf_cnt, rf_first, LAT);
    end
  endtask

  task automatic test_clean_press();
    key_in = 1'b0;
    watch(30);
    n_vec++;
    if (kf_cnt !== 1 || kf_first !== LAT) begin
      n_err++;
      $display("FAIL clean_press_flag: count %0d at %0d, expected 1 at %0d", kf_cnt, kf_first, LAT);
    end
    n_vec++;
    if (ks_hist[LAT-1] !== 1'b0 || ks_hist[LAT] !== 1'b1 || key_state !== 1'b1) begin
      n_err++;
      $display("FAIL clean_press_state: before %b at %b end %b, expected 0 1 1",
               ks_hist[LAT-1], ks_hist[LAT], key_state);
    end
    n_vec++;
    if (rf_cnt !== 0 || lf_cnt !== 0) begin
      n_err++;
      $display("FAIL clean_press_other: rel %0d long %0d, expected 0 0", rf_cnt, lf_cnt);
    end
    key_in = 1'b1;
    watch(20);
    n_vec++;
    if (rf_cnt !== 1 || rf_first !== LAT || key_state !== 1'b0) begin
      n_err++;
      $display("FAIL clean_release: rel count %0d at %0d state %b, expected 1 at %0d state 0",
               rf_cnt, rf_first, key_state, LAT);
    end
  endtask

  task automatic test_bounce();
    int early;
    early = 0;
    key_in = 1'b0; watch(5); early += kf_cnt + rf_cnt;
    key_in = 1'b1; watch(2); early += kf_cnt + rf_cnt;
    key_in = 1'b0; watch(4); early += kf_cnt + rf_cnt;
    key_in = 1'b1; watch(3); early += kf_cnt + rf_cnt;
    n_vec++;
    if (early !== 0) begin
      n_err++;
      $display("FAIL bounce_early: %0d flags during bounce, expected 0", early);
    end
    key_in = 1'b0;
    watch(25);
    n_vec++;
    if (kf_cnt !== 1 || kf_first !== LAT) begin
      n_err++;
      $display("FAIL bounce_press: count %0d at %0d, expected 1 at %0d", kf_cnt, kf_first, LAT);
    end
  endtask

  task automatic test_release_bounce();
    int extra;
    extra = 0;
    key_in = 1'b1; watch(4); extra += kf_cnt + rf_cnt;
    key_in = 1'b0; watch(1); extra += kf_cnt + rf_cnt;
    key_in = 1'b1;
    watch(20);
    n_vec++;
    if (extra !== 0 || kf_cnt !== 0) begin
      n_err++;
      $display("FAIL rel_bounce_extra: %0d early flags, %0d key_flag, expected 0 0", extra, kf_cnt);
    end
    n_vec++;
    if (rf_cnt !== 1 || rf_first !== LAT) begin
      n_err++;
      $display("FAIL rel_bounce_flag: count %0d at %0d, expected 1 at %0d", rf_cnt, rf_first, LAT);
    end
    n_vec++;
    if (ks_hist[LAT-1] !== 1'b1 || ks_hist[LAT] !== 1'b0) begin
      n_err++;
      $display("FAIL rel_bounce_state: before %b at %b, expected 1 0", ks_hist[LAT-1], ks_hist[LAT]);
    end
  endtask

  task automatic test_long_press();
    int exp_lf_cnt, exp_lf_first;
`ifdef KEY_LONG_PRESS_EN
    exp_lf_cnt = 1; exp_lf_first = LAT + LONG_MAX;
`else
    exp_lf_cnt = 0; exp_lf_first = -1;
`endif
    key_in = 1'b0;
    watch(100);
    n_vec++;
    if (kf_cnt !== 1 || kf_first !== LAT) begin
      n_err++;
      $display("FAIL long_key_flag: count %0d at %0d, expected 1 at %0d", kf_cnt, kf_first, LAT);
    end
    n_vec++;
    if (lf_cnt !== exp_lf_cnt || lf_first !== exp_lf_first) begin
      n_err++;
      $display("FAIL long_flag: count %0d at %0d, expected %0d at %0d", lf_cnt, lf_first, exp_lf_cnt, exp_lf_first);
    end
    n_vec++;
    if (multi_cnt !== 0) begin
      n_err++;
      $display("FAIL flag_exclusive: %0d overlapping cycles, expected 0", multi_cnt);
    end
    key_in = 1'b1;
    watch(20);
    n_vec++;
    if (rf_cnt !== 1 || lf_cnt !== 0) begin
      n_err++;
      $display("FAIL long_release: rel %0d long %0d, expected 1 0", rf_cnt, lf_cnt);
    end
  endtask

  task automatic test_reset_mid();
    key_in = 1'b0;
    watch(9);
    rst = 1'b1;
    step();
    n_vec++;
    if (kf_cnt !== 0 || {key_flag, rel_flag, key_state, long_flag} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_mid_clear: flags %0d outputs %b, expected 0 0000",
               kf_cnt, {key_flag, rel_flag, key_state, long_flag});
    end
    rst = 1'b0;
    watch(20);
    n_vec++;
    if (kf_cnt !== 1 || kf_first !== LAT) begin
      n_err++;
      $display("FAIL reset_mid_refilter: count %0d at %0d, expected 1 at %0d", kf_cnt, kf_first, LAT);
    end
    key_in = 1'b1;
    watch(20);
  endtask

  initial begin
    rst = 1'b1;
    key_in = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_long_press();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
